// File: rtl/s713_response_misr_pkg.sv
// Shared constants for the s713 response compactor.
//   S713_OUT_WIDTH : number of s713 primary outputs folded per sample
//   MISR_POLY      : default MISR feedback polynomial
//   MISR_SEED      : default MISR value loaded when a run starts
//   ST_*           : FSM state encodings of the top-level controller
package s713_response_misr_pkg;

  localparam int unsigned S713_OUT_WIDTH = 23;

  localparam logic [31:0] MISR_POLY = 32'h04C11DB7;
  localparam logic [31:0] MISR_SEED = 32'hFFFFFFFF;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/s713_response_misr_misr.sv
// Multiple-input signature register: shift left, fold in POLY when the MSB
// leaves, XOR in the zero-extended data word.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (register clears to 0)
//   load      : load seed (takes priority over en)
//   seed      : value loaded by load
//   en        : fold data into the register this cycle
//   data      : parallel input word
//   sig       : current register contents
//   sig_next  : value the register takes if en is asserted this cycle
module misr_core
  import s713_response_misr_pkg::*;
#(
  parameter int unsigned          SIG_WIDTH  = 32,
  parameter int unsigned          DATA_WIDTH = S713_OUT_WIDTH,
  parameter logic [SIG_WIDTH-1:0] POLY       = MISR_POLY
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [SIG_WIDTH-1:0]  seed,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [SIG_WIDTH-1:0]  sig,
  output logic [SIG_WIDTH-1:0]  sig_next
);

  logic [SIG_WIDTH-1:0] sig_q, sig_d;

  always_comb begin
    sig_next = {sig_q[SIG_WIDTH-2:0], 1'b0}
             ^ (sig_q[SIG_WIDTH-1] ? POLY : '0)
             ^ SIG_WIDTH'(data);
    sig_d = sig_q;
    if (load) begin
      sig_d = seed;
    end else if (en) begin
      sig_d = sig_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/s713_response_misr.sv
// Response compactor for the s713 core: folds num_samples valid output
// vectors into a MISR and compares the final signature with a golden value.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   start        : begin a run (accepted in IDLE/DONE, ignored in RUN)
//   num_samples  : samples to compact, captured on accepted start
//   expected     : golden signature, captured on accepted start
//   valid_in     : dut_out carries a sample this cycle
//   dut_out      : s713 primary outputs, LSB = G106BF
//   busy         : run in progress
//   done         : run finished; holds until the next accepted start
//   pass         : signature matched expected (valid while done)
//   signature    : current MISR contents
//   count        : samples accepted in the current run
module s713_response_misr
  import s713_response_misr_pkg::*;
#(
  parameter int unsigned          DATA_WIDTH = S713_OUT_WIDTH,
  parameter int unsigned          SIG_WIDTH  = 32,
  parameter logic [SIG_WIDTH-1:0] POLY       = MISR_POLY,
  parameter logic [SIG_WIDTH-1:0] SEED       = MISR_SEED,
  parameter int unsigned          CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  num_samples,
  input  logic [SIG_WIDTH-1:0]  expected,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] dut_out,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [SIG_WIDTH-1:0]  signature,
  output logic [CNT_WIDTH-1:0]  count
);

  logic [1:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [CNT_WIDTH-1:0] num_q, num_d;
  logic [SIG_WIDTH-1:0] exp_q, exp_d;
  logic                 pass_q, pass_d;

  logic                 misr_load;
  logic                 misr_en;
  logic [SIG_WIDTH-1:0] sig;
  logic [SIG_WIDTH-1:0] sig_next;

  misr_core #(
    .SIG_WIDTH  (SIG_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .POLY       (POLY)
  ) u_misr (
    .clk      (clk),
    .rst      (rst),
    .load     (misr_load),
    .seed     (SEED),
    .en       (misr_en),
    .data     (dut_out),
    .sig      (sig),
    .sig_next (sig_next)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    num_d     = num_q;
    exp_d     = exp_q;
    pass_d    = pass_q;
    misr_load = 1'b0;
    misr_en   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        // A sample arriving with start is dropped: the run begins from SEED.
        if (start) begin
          misr_load = 1'b1;
          count_d   = '0;
          num_d     = num_samples;
          exp_d     = expected;
          if (num_samples == '0) begin
            state_d = ST_DONE;
            pass_d  = (SEED == expected);
          end else begin
            state_d = ST_RUN;
            pass_d  = 1'b0;
          end
        end
      end
      ST_RUN: begin
        if (valid_in) begin
          misr_en = 1'b1;
          count_d = count_q + CNT_WIDTH'(1);
          // Last sample: compare against the post-update signature so pass
          // lands on the same edge as done.
          if (count_q == num_q - CNT_WIDTH'(1)) begin
            state_d = ST_DONE;
            pass_d  = (sig_next == exp_q);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      num_q   <= '0;
      exp_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      num_q   <= num_d;
      exp_q   <= exp_d;
      pass_q  <= pass_d;
    end
  end

  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign pass      = pass_q;
  assign signature = sig;
  assign count     = count_q;

endmodule

// File: tb/tb_s713_response_misr.sv
module tb_s713_response_misr;

  localparam logic [31:0] POLY = 32'h04C11DB7;
  localparam logic [31:0] SEED = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] num_samples = '0;
  logic [31:0] expected = '0;
  logic        valid_in = 1'b0;
  logic [22:0] dut_out = '0;
  logic        busy, done, pass;
  logic [31:0] signature;
  logic [15:0] count;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  s713_response_misr dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_samples (num_samples),
    .expected    (expected),
    .valid_in    (valid_in),
    .dut_out     (dut_out),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .signature   (signature),
    .count       (count)
  );

  function automatic logic [31:0] model_step(input logic [31:0] s, input logic [22:0] d);
    logic [31:0] r;
    r = {s[30:0], 1'b0};
    if (s[31]) r = r ^ POLY;
    return r ^ {9'd0, d};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic b, input logic d, input logic p,
                          input logic [31:0] s, input logic [15:0] c);
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
    chk({tag, ".done"}, {31'd0, done}, {31'd0, d});
    chk({tag, ".pass"}, {31'd0, pass}, {31'd0, p});
    chk({tag, ".sig"}, signature, s);
    chk({tag, ".count"}, {16'd0, count}, {16'd0, c});
  endtask

  // Drives start for one edge; inputs change on negedge, outputs sampled on negedge.
  task automatic do_start(input logic [15:0] n, input logic [31:0] e);
    start = 1'b1; num_samples = n; expected = e;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic sample(input logic v, input logic [22:0] d);
    valid_in = v; dut_out = d;
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [15:0] num;
    logic [31:0] exp_in;
    logic [22:0] d0;
    logic [22:0] d1;
    logic [31:0] want_sig;
    logic        want_pass;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [31:0] m;
    logic [31:0] gold;
    logic [22:0] gdat [7];
    logic        gval [7];
    int          cnt;

    vecs[0] = '{"one_d1_match",  16'd1, 32'hFB3EE248, 23'h000001, 23'h0, 32'hFB3EE248, 1'b1};
    vecs[1] = '{"one_d1_miss",   16'd1, 32'hFB3EE249, 23'h000001, 23'h0, 32'hFB3EE248, 1'b0};
    vecs[2] = '{"one_d0_match",  16'd1, 32'hFB3EE249, 23'h000000, 23'h0, 32'hFB3EE249, 1'b1};
    vecs[3] = '{"one_ones_miss", 16'd1, 32'h00000000, 23'h7FFFFF, 23'h0, 32'hFB411DB6, 1'b0};
    vecs[4] = '{"zero_match",    16'd0, 32'hFFFFFFFF, 23'h0,      23'h0, 32'hFFFFFFFF, 1'b1};
    vecs[5] = '{"two_zeros",     16'd2, 32'hF2BCD925, 23'h000000, 23'h0, 32'hF2BCD925, 1'b1};

    // Reset state
    @(negedge clk);
    chk_outs("reset", 1'b0, 1'b0, 1'b0, 32'h0, 16'h0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven single runs
    for (int i = 0; i < 6; i++) begin
      do_start(vecs[i].num, vecs[i].exp_in);
      if (vecs[i].num == 16'd0) begin
        chk_outs(vecs[i].name, 1'b0, 1'b1, vecs[i].want_pass, vecs[i].want_sig, 16'd0);
      end else begin
        chk({vecs[i].name, ".busy_run"}, {31'd0, busy}, 32'd1);
        for (int k = 0; k < int'(vecs[i].num); k++) sample(1'b1, (k == 0) ? vecs[i].d0 : vecs[i].d1);
        chk_outs(vecs[i].name, 1'b0, 1'b1, vecs[i].want_pass, vecs[i].want_sig, vecs[i].num);
      end
    end
    // num_samples=0 with mismatching expected
    do_start(16'd0, 32'h0);
    chk_outs("zero_miss", 1'b0, 1'b1, 1'b0, SEED, 16'd0);

    // Reset in the middle of a run
    do_start(16'd5, 32'h0);
    for (int k = 0; k < 3; k++) sample(1'b1, 23'h5A5A5);
    chk("pre_rst.count", {16'd0, count}, 32'd3);
    rst = 1'b1;
    #1;
    chk_outs("mid_rst", 1'b0, 1'b0, 1'b0, 32'h0, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_outs("post_rst", 1'b0, 1'b0, 1'b0, 32'h0, 16'd0);
    do_start(16'd1, 32'hFB3EE249);
    sample(1'b1, 23'h0);
    chk_outs("after_rst_run", 1'b0, 1'b1, 1'b1, 32'hFB3EE249, 16'd1);

    // Gapped valid_in, checked per cycle against the model
    gval = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    gdat = '{23'h000011, 23'h3FFFFF, 23'h222222, 23'h0ABCDE, 23'h7FFFFF, 23'h111111, 23'h123456};
    gold = SEED;
    for (int i = 0; i < 7; i++) if (gval[i]) gold = model_step(gold, gdat[i]);
    do_start(16'd4, gold);
    m = SEED;
    cnt = 0;
    for (int i = 0; i < 7; i++) begin
      if (gval[i]) begin
        m = model_step(m, gdat[i]);
        cnt++;
      end
      sample(gval[i], gdat[i]);
      chk($sformatf("gap%0d.count", i), {16'd0, count}, cnt);
      chk($sformatf("gap%0d.sig", i), signature, m);
      chk($sformatf("gap%0d.done", i), {31'd0, done}, (i == 6) ? 32'd1 : 32'd0);
    end
    chk("gap.pass", {31'd0, pass}, 32'd1);
    sample(1'b1, 23'h7FFFFF);
    chk_outs("gap_done_hold", 1'b0, 1'b1, 1'b1, m, 16'd4);

    // start mid-run is ignored; restart from DONE drops a concurrent sample
    do_start(16'd3, 32'h0);
    m = SEED;
    m = model_step(m, 23'h000101);
    sample(1'b1, 23'h000101);
    start = 1'b1; num_samples = 16'd2; expected = 32'hFFFFFFFF;
    @(negedge clk);
    start = 1'b0;
    chk("midstart.busy", {31'd0, busy}, 32'd1);
    chk("midstart.count", {16'd0, count}, 32'd1);
    chk("midstart.sig", signature, m);
    m = model_step(m, 23'h040404);
    sample(1'b1, 23'h040404);
    chk("midstart.done2", {31'd0, done}, 32'd0);
    m = model_step(m, 23'h7F0000);
    sample(1'b1, 23'h7F0000);
    chk_outs("midstart_end", 1'b0, 1'b1, (m == 32'h0), m, 16'd3);
    valid_in = 1'b1; dut_out = 23'h001234;
    do_start(16'd1, 32'hFB3EE249);
    valid_in = 1'b0;
    chk_outs("restart", 1'b1, 1'b0, 1'b0, SEED, 16'd0);
    sample(1'b1, 23'h0);
    chk_outs("restart_end", 1'b0, 1'b1, 1'b1, 32'hFB3EE249, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
